// File: rtl/z3_autoconfig_master.sv
// Zorro III AutoConfig initiator: reads a board's ID nibbles over config
// cycles, then writes its base nibble or shuts it up and waits for CFGOUT_n.
module z3_autoconfig_master #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        RESET_n,
   input  logic        start,
   input  logic        shutup_req,
   input  logic [3:0]  base_nib,
   output logic        FCS_n,
   output logic        DS_n,
   output logic        READ,
   output logic [2:0]  FC,
   output logic [6:0]  ADDRL,
   output logic        CFG_SEL,
   output logic        CFGIN_n,
   output logic [3:0]  DOUT,
   input  logic [3:0]  DIN,
   input  logic        DTACK,
   input  logic        CFGOUT_n,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  er_type,
   output logic [7:0]  prod_id,
   output logic [7:0]  er_flags,
   output logic [15:0] mfg_id,
   output logic [31:0] serial
);

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ASSERT, S_STROBE,
      S_RELEASE, S_NEXT, S_WAITCFG, S_DONE
   } state_t;

   state_t      st_q, st_d;
   logic [15:0] tmr_q, tmr_d;
   logic [6:0]  idx_q, idx_d;
   logic        wr_q, wr_d;
   logic        shutup_q, shutup_d;
   logic [3:0]  base_q, base_d;
   logic        fcs_n_q, fcs_n_d, ds_n_q, ds_n_d;
   logic        read_q, read_d, cfg_sel_q, cfg_sel_d;
   logic        cfgin_n_q, cfgin_n_d;
   logic [2:0]  fc_q, fc_d;
   logic [6:0]  addrl_q, addrl_d;
   logic [3:0]  dout_q, dout_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  er_type_q, er_type_d, prod_id_q, prod_id_d;
   logic [7:0]  er_flags_q, er_flags_d;
   logic [15:0] mfg_id_q, mfg_id_d;
   logic [31:0] serial_q, serial_d;

   logic        ld, ld_wr, fin, rel;
   logic [6:0]  ld_idx;
   logic [1:0]  fin_code;

   always_comb begin
      st_d       = st_q;
      tmr_d      = tmr_q;
      idx_d      = idx_q;
      wr_d       = wr_q;
      shutup_d   = shutup_q;
      base_d     = base_q;
      fcs_n_d    = fcs_n_q;
      ds_n_d     = ds_n_q;
      read_d     = read_q;
      cfg_sel_d  = cfg_sel_q;
      cfgin_n_d  = cfgin_n_q;
      fc_d       = fc_q;
      addrl_d    = addrl_q;
      dout_d     = dout_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      er_type_d  = er_type_q;
      prod_id_d  = prod_id_q;
      er_flags_d = er_flags_q;
      mfg_id_d   = mfg_id_q;
      serial_d   = serial_q;
      ld         = 1'b0;
      ld_wr      = 1'b0;
      ld_idx     = 7'h00;
      fin        = 1'b0;
      fin_code   = 2'd0;
      rel        = 1'b0;

      unique case (st_q)
         S_IDLE, S_DONE: begin
            st_d = S_IDLE;
            if (start) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               err_code_d = 2'd0;
               er_type_d  = '0;
               prod_id_d  = '0;
               er_flags_d = '0;
               mfg_id_d   = '0;
               serial_d   = '0;
               shutup_d   = shutup_req;
               base_d     = base_nib;
               busy_d     = 1'b1;
               cfgin_n_d  = 1'b0;
               idx_d      = 7'h00;
               wr_d       = 1'b0;
               ld         = 1'b1;
            end
         end
         S_SETUP: begin
            if (tmr_q == SETUP_LAST) begin
               st_d    = S_ASSERT;
               tmr_d   = '0;
               fcs_n_d = 1'b0;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_ASSERT: begin
            st_d   = S_STROBE;
            tmr_d  = '0;
            ds_n_d = 1'b0;
         end
         S_STROBE: begin
            if (DTACK) begin
               // fields arrive high nibble first, so shift them in
               if (!wr_q) begin
                  if (idx_q < 7'h02)
                     er_type_d = {er_type_q[3:0], DIN};
                  else if (idx_q < 7'h04)
                     prod_id_d = {prod_id_q[3:0], ~DIN};
                  else if (idx_q < 7'h06)
                     er_flags_d = {er_flags_q[3:0], ~DIN};
                  else if (idx_q < 7'h0C)
                     mfg_id_d = {mfg_id_q[11:0], ~DIN};
                  else
                     serial_d = {serial_q[27:0], ~DIN};
               end
               st_d  = S_RELEASE;
               tmr_d = '0;
               rel   = 1'b1;
            end else if (tmr_q == TMO_LAST) begin
               fin      = 1'b1;
               fin_code = 2'd1;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_RELEASE: begin
            if (!DTACK) begin
               st_d  = S_NEXT;
               tmr_d = '0;
            end else if (tmr_q == TMO_LAST) begin
               fin      = 1'b1;
               fin_code = 2'd1;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_NEXT: begin
            if (wr_q) begin
               st_d  = S_WAITCFG;
               tmr_d = '0;
            end else if (idx_q == 7'h13) begin
               if (er_type_q[7:6] != 2'b10) begin
                  fin      = 1'b1;
                  fin_code = 2'd2;
               end else begin
                  wr_d  = 1'b1;
                  ld    = 1'b1;
                  ld_wr = 1'b1;
               end
            end else begin
               ld_idx = (idx_q == 7'h05) ? 7'h08 : idx_q + 7'd1;
               idx_d  = ld_idx;
               ld     = 1'b1;
            end
         end
         S_WAITCFG: begin
            if (!CFGOUT_n) begin
               fin = 1'b1;
            end else if (tmr_q == TMO_LAST) begin
               fin      = 1'b1;
               fin_code = 2'd3;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         default: st_d = S_IDLE;
      endcase

      if (ld) begin
         st_d      = S_SETUP;
         tmr_d     = '0;
         fc_d      = 3'b101;
         cfg_sel_d = 1'b1;
         read_d    = !ld_wr;
         addrl_d   = ld_wr ? (shutup_q ? 7'h13 : 7'h11)
                           : {ld_idx[0], ld_idx[6:1]};
         dout_d    = (ld_wr && !shutup_q) ? base_q : 4'h0;
      end

      if (rel || fin) begin
         fcs_n_d   = 1'b1;
         ds_n_d    = 1'b1;
         cfg_sel_d = 1'b0;
         fc_d      = 3'b000;
         dout_d    = 4'h0;
      end

      if (fin) begin
         st_d       = S_DONE;
         tmr_d      = '0;
         read_d     = 1'b1;
         addrl_d    = 7'h00;
         busy_d     = 1'b0;
         cfgin_n_d  = 1'b1;
         done_d     = 1'b1;
         err_d      = (fin_code != 2'd0);
         err_code_d = fin_code;
      end
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         st_q       <= S_IDLE;
         tmr_q      <= '0;
         idx_q      <= '0;
         wr_q       <= 1'b0;
         shutup_q   <= 1'b0;
         base_q     <= '0;
         fcs_n_q    <= 1'b1;
         ds_n_q     <= 1'b1;
         read_q     <= 1'b1;
         cfg_sel_q  <= 1'b0;
         cfgin_n_q  <= 1'b1;
         fc_q       <= '0;
         addrl_q    <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         er_type_q  <= '0;
         prod_id_q  <= '0;
         er_flags_q <= '0;
         mfg_id_q   <= '0;
         serial_q   <= '0;
      end else begin
         st_q       <= st_d;
         tmr_q      <= tmr_d;
         idx_q      <= idx_d;
         wr_q       <= wr_d;
         shutup_q   <= shutup_d;
         base_q     <= base_d;
         fcs_n_q    <= fcs_n_d;
         ds_n_q     <= ds_n_d;
         read_q     <= read_d;
         cfg_sel_q  <= cfg_sel_d;
         cfgin_n_q  <= cfgin_n_d;
         fc_q       <= fc_d;
         addrl_q    <= addrl_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         er_type_q  <= er_type_d;
         prod_id_q  <= prod_id_d;
         er_flags_q <= er_flags_d;
         mfg_id_q   <= mfg_id_d;
         serial_q   <= serial_d;
      end
   end

   assign FCS_n    = fcs_n_q;
   assign DS_n     = ds_n_q;
   assign READ     = read_q;
   assign FC       = fc_q;
   assign ADDRL    = addrl_q;
   assign CFG_SEL  = cfg_sel_q;
   assign CFGIN_n  = cfgin_n_q;
   assign DOUT     = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign er_type  = er_type_q;
   assign prod_id  = prod_id_q;
   assign er_flags = er_flags_q;
   assign mfg_id   = mfg_id_q;
   assign serial   = serial_q;

endmodule

// File: tb/tb_z3_autoconfig_master.sv
// Bench for z3_autoconfig_master: behavioural config slave with random
// handshake delays and ROM contents, checked against a field-level ID model.
module tb_z3_autoconfig_master;

   localparam int TMO = 40;

   logic        CLK = 1'b0;
   logic        RESET_n, start, shutup_req;
   logic [3:0]  base_nib, DIN, DOUT;
   logic        DTACK, CFGOUT_n;
   logic        FCS_n, DS_n, READ, CFG_SEL, CFGIN_n;
   logic [2:0]  FC;
   logic [6:0]  ADDRL;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [7:0]  er_type, prod_id, er_flags;
   logic [15:0] mfg_id;
   logic [31:0] serial;

   always #5 CLK = ~CLK;

   z3_autoconfig_master #(.SETUP_CYC(2), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET_n(RESET_n), .start(start),
      .shutup_req(shutup_req), .base_nib(base_nib),
      .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ), .FC(FC),
      .ADDRL(ADDRL), .CFG_SEL(CFG_SEL), .CFGIN_n(CFGIN_n),
      .DOUT(DOUT), .DIN(DIN), .DTACK(DTACK), .CFGOUT_n(CFGOUT_n),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .er_type(er_type), .prod_id(prod_id), .er_flags(er_flags),
      .mfg_id(mfg_id), .serial(serial)
   );

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge CLK) cyc++;

   // slave model
   logic [3:0]  rom [0:127];
   int          dly, rel, cur_idx, hang_idx;
   bit          dtack_dead, cfg_stuck, in_cyc, cur_rd, prev_fcs;
   bit          configured, shut;
   int          n_strobe, n_wr, proto_bad, wr_ack_cyc;
   int unsigned rd_sig;
   logic [6:0]  cur_addrl, wr_addr;
   logic [3:0]  wr_data, addr_match;

   always @(negedge CLK) begin
      if (!RESET_n) begin
         DTACK = 1'b0;
         in_cyc = 1'b0;
         prev_fcs = 1'b1;
      end else begin
         if (prev_fcs && !FCS_n) begin
            if (DTACK) proto_bad++;
            if (FC != 3'b101 || !CFG_SEL || CFGIN_n) proto_bad++;
            n_strobe++;
            cur_addrl = ADDRL;
            cur_idx = int'({ADDRL[5:0], ADDRL[6]});
            cur_rd = READ;
            if (READ) rd_sig = rd_sig * 31 + cur_idx;
            dly = $urandom_range(0, 3);
            in_cyc = 1'b1;
         end
         if (in_cyc && !DS_n && !DTACK && !dtack_dead
             && cur_idx != hang_idx) begin
            if (dly > 0) dly--;
            else begin
               DTACK = 1'b1;
               in_cyc = 1'b0;
               rel = $urandom_range(0, 3);
               if (cur_rd) DIN = rom[cur_idx];
               else begin
                  n_wr++;
                  wr_addr = cur_addrl;
                  wr_data = DOUT;
                  wr_ack_cyc = cyc;
                  if (cur_addrl == 7'h11) begin
                     addr_match = DOUT;
                     configured = 1'b1;
                  end
                  if (cur_addrl == 7'h13) shut = 1'b1;
                  if (!cfg_stuck) CFGOUT_n = 1'b0;
               end
            end
         end else if (DTACK && DS_n) begin
            if (rel > 0) rel--;
            else DTACK = 1'b0;
         end
         prev_fcs = FCS_n;
      end
   end

   task automatic slave_init();
      n_strobe = 0; n_wr = 0; proto_bad = 0; rd_sig = 0;
      configured = 0; shut = 0; addr_match = 0;
      wr_addr = 0; wr_data = 0; wr_ack_cyc = 0;
      CFGOUT_n = 1'b1; dtack_dead = 0; cfg_stuck = 0; hang_idx = -1;
   endtask

   task automatic load_id(input logic [7:0] ty, input logic [7:0] pr,
                          input logic [7:0] fl, input logic [15:0] mf,
                          input logic [31:0] sn);
      rom[0] = ty[7:4];  rom[1] = ty[3:0];
      rom[2] = ~pr[7:4]; rom[3] = ~pr[3:0];
      rom[4] = ~fl[7:4]; rom[5] = ~fl[3:0];
      for (int k = 0; k < 4; k++) rom[8 + k] = ~mf[(3 - k) * 4 +: 4];
      for (int k = 0; k < 8; k++) rom[12 + k] = ~sn[(7 - k) * 4 +: 4];
   endtask

   function automatic int unsigned list_sig(input int n);
      int unsigned s;
      int idx;
      s = 0;
      idx = 0;
      for (int k = 0; k < n; k++) begin
         s = s * 31 + idx;
         idx = (idx == 5) ? 8 : idx + 1;
      end
      return s;
   endfunction

   task automatic pulse_start(input bit su, input logic [3:0] bn);
      @(negedge CLK);
      shutup_req = su;
      base_nib = bn;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      shutup_req = ~su;
      base_nib = ~bn;
   endtask

   task automatic wait_done(input string nm, output int ncyc);
      bit ok;
      ok = 0;
      ncyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (done) begin
            ok = 1;
            ncyc = i + 1;
            break;
         end
      end
      check({nm, ".done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic run_case(input string nm, input bit su,
                           input logic [3:0] bn, input bit stuck,
                           input bit dead, input bit poke);
      logic [7:0]  e_ty, e_pr, e_fl;
      logic [15:0] e_mf;
      logic [31:0] e_sn;
      logic [1:0]  e_code;
      int          e_str, e_wr, ncyc, t0;
      @(posedge CLK); #1;
      slave_init();
      cfg_stuck = stuck;
      dtack_dead = dead;
      pulse_start(su, bn);
      t0 = cyc;
      check({nm, ".busy"}, {done, busy, CFGIN_n}, 3'b010);
      if (poke) begin
         repeat (20) @(negedge CLK);
         pulse_start(~su, ~bn);
      end
      wait_done(nm, ncyc);

      e_ty = {rom[0], rom[1]};
      e_pr = ~{rom[2], rom[3]};
      e_fl = ~{rom[4], rom[5]};
      e_mf = ~{rom[8], rom[9], rom[10], rom[11]};
      e_sn = ~{rom[12], rom[13], rom[14], rom[15],
               rom[16], rom[17], rom[18], rom[19]};
      if (dead) begin
         e_code = 2'd1; e_str = 1; e_wr = 0;
         e_ty = 0; e_pr = 0; e_fl = 0; e_mf = 0; e_sn = 0;
      end else if (e_ty[7:6] != 2'b10) begin
         e_code = 2'd2; e_str = 18; e_wr = 0;
      end else begin
         e_code = stuck ? 2'd3 : 2'd0; e_str = 19; e_wr = 1;
      end

      check({nm, ".code"}, 32'(err_code), 32'(e_code));
      check({nm, ".ctl"}, {done, err, busy, CFGIN_n, FCS_n, DS_n, CFG_SEL},
            {1'b1, e_code != 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      check({nm, ".er_type"}, 32'(er_type), 32'(e_ty));
      check({nm, ".prod_id"}, 32'(prod_id), 32'(e_pr));
      check({nm, ".er_flags"}, 32'(er_flags), 32'(e_fl));
      check({nm, ".mfg_id"}, 32'(mfg_id), 32'(e_mf));
      check({nm, ".serial"}, serial, e_sn);
      check({nm, ".strobes"}, 32'(n_strobe), 32'(e_str));
      check({nm, ".rd_order"}, rd_sig, list_sig(dead ? 1 : 18));
      check({nm, ".writes"}, 32'(n_wr), 32'(e_wr));
      check({nm, ".proto"}, 32'(proto_bad), 32'd0);
      if (e_wr == 1) begin
         check({nm, ".wr_addr"}, 32'(wr_addr), su ? 32'h13 : 32'h11);
         check({nm, ".wr_data"}, 32'(wr_data), su ? 32'h0 : 32'(bn));
         check({nm, ".cfg"}, {configured, shut, addr_match},
               {!su, su, su ? 4'h0 : bn});
      end
      if (dead)
         check({nm, ".tmo_win"},
               32'((ncyc >= TMO) && (ncyc <= TMO + 8)), 32'd1);
      if (stuck && e_wr == 1)
         check({nm, ".cfg_win"},
               32'((cyc - wr_ack_cyc >= TMO) && (cyc - wr_ack_cyc <= TMO + 10)),
               32'd1);
      if (t0 < 0) $display("unreachable");
   endtask

   task automatic check_reset(input string nm);
      check({nm, ".ctl"}, {FCS_n, DS_n, READ, CFGIN_n, CFG_SEL, busy, done, err},
            8'hF0);
      check({nm, ".bus"}, {FC, ADDRL, DOUT, err_code}, 16'h0);
      check({nm, ".ids"}, 32'(|{er_type, prod_id, er_flags, mfg_id, serial}),
            32'd0);
   endtask

   initial begin
      bit ok;
      RESET_n = 1'b1; start = 1'b0; shutup_req = 1'b0; base_nib = 4'h0;
      DIN = 4'h0; DTACK = 1'b0; CFGOUT_n = 1'b1;
      slave_init();
      for (int i = 0; i < 128; i++) rom[i] = 4'hF;
      #2 RESET_n = 1'b0;
      #1 check_reset("reset");
      repeat (2) @(negedge CLK);
      RESET_n = 1'b1;

      load_id(8'hA4, 8'h72, 8'hB1, 16'h07DB, 32'h000001A5);
      run_case("t1_base", 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
      check("t1.consts", {er_type, prod_id, er_flags, mfg_id}, 40'hA472B107DB);
      check("t1.serial", serial, 32'h000001A5);

      run_case("t2_shutup", 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
      check("t2.cfgout", 32'(CFGOUT_n), 32'd0);

      run_case("t3_dead", 1'b0, 4'h4, 1'b0, 1'b1, 1'b0);

      rom[0] = 4'h0; rom[1] = 4'h0;
      run_case("t4_notz3", 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);

      load_id(8'hA4, 8'h72, 8'hB1, 16'h07DB, 32'h000001A5);
      run_case("t5_stuck", 1'b0, 4'h9, 1'b1, 1'b0, 1'b0);

      @(posedge CLK); #1;
      slave_init();
      hang_idx = 9;
      pulse_start(1'b0, 4'h4);
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (in_cyc && cur_idx == 9 && !DS_n) begin
            ok = 1;
            break;
         end
      end
      check("t6.reached", 32'(ok), 32'd1);
      repeat (3) @(negedge CLK);
      check("t6.strobe", {FCS_n, DS_n}, 2'b00);
      RESET_n = 1'b0;
      #1 check_reset("t6_rst");
      @(negedge CLK);
      RESET_n = 1'b1;
      hang_idx = -1;
      run_case("t6_rerun", 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
      check("t6.match", {configured, addr_match}, 5'h14);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 20; i++) rom[i] = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0) rom[0][3:2] = 2'b10;
         run_case($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) == 0, 1'b0, r[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
